// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: redirect codes, fetch states, NOP word.
package fetch_unit_pkg;

  localparam logic [1:0] JB_NONE   = 2'b00;
  localparam logic [1:0] JB_BRANCH = 2'b01;
  localparam logic [1:0] JB_JUMP   = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {REQ, WAIT} fetch_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus: valid/ready request, in-order rvalid response.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word (and its PC+4) that arrived during a stall.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= 32'h0;
      pc4   <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc4   <= load_pc4;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem request FSM, kill flag and IF/ID register.
//   state | meaning
//   REQ   | request imem at pc (held off while the skid buffer is full)
//   WAIT  | one request outstanding, waiting for rvalid
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic [1:0]   jb_flag,
  input  logic [31:0]  branch_addr,
  input  logic [31:0]  jump_addr,
  fetch_unit_if.master imem,
  output logic [31:0]  if_id_instr,
  output logic [31:0]  if_id_pc4,
  output logic         if_id_valid
);
  import fetch_unit_pkg::*;

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, fetch_pc4, target, buf_instr, buf_pc4;
  logic         kill, redirect, accept, rsp, deliver, buf_valid;

  assign redirect  = (jb_flag != JB_NONE) && !stall;
  assign target    = align_word((jb_flag == JB_BRANCH) ? branch_addr : jump_addr);
  assign accept    = imem.req && imem.ready;
  assign rsp       = (state == WAIT) && imem.rvalid;
  assign deliver   = rsp && !kill && !redirect;
  assign imem.addr = pc;

  always_comb begin
    state_nxt = state;
    imem.req  = 1'b0;
    unique case (state)
      REQ: begin
        imem.req = !buf_valid && !reset;
        if (!buf_valid && !reset && imem.ready) state_nxt = WAIT;
      end
      WAIT: if (imem.rvalid) state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= REQ;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      fetch_pc4 <= 32'h0;
    end else begin
      if (redirect)    pc <= target;
      else if (accept) pc <= pc + 32'd4;
      if (accept) fetch_pc4 <= pc + 32'd4;
    end
  end

  // A response landing this cycle is already dropped by the redirect, so nothing is left to kill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    kill <= 1'b0;
    else if (rsp)                                 kill <= 1'b0;
    else if (redirect && (state == WAIT || accept)) kill <= 1'b1;
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (deliver && stall),
    .drain      (!stall),
    .clear      (redirect),
    .load_instr (imem.rdata),
    .load_pc4   (fetch_pc4),
    .valid      (buf_valid),
    .instr      (buf_instr),
    .pc4        (buf_pc4)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if (redirect) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end else if (buf_valid) begin
        if_id_valid <= 1'b1;
        if_id_instr <= buf_instr;
        if_id_pc4   <= buf_pc4;
      end else if (deliver) begin
        if_id_valid <= 1'b1;
        if_id_instr <= imem.rdata;
        if_id_pc4   <= fetch_pc4;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for streaming/redirect/ready-low, hand sequences for stall, kill and reset.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct {
    logic        stall;
    logic [1:0]  jb;
    logic [31:0] br;
    logic [31:0] jp;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  jb_flag = 2'b00;
  logic [31:0] branch_addr = 32'h0;
  logic [31:0] jump_addr = 32'h0;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .jb_flag     (jb_flag),
    .branch_addr (branch_addr),
    .jump_addr   (jump_addr),
    .imem        (bus),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          mem_lat = 1;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] ovr_addr = 32'hFFFF_FFFF;
  logic [31:0] ovr_word = 32'h0;

  function automatic logic [31:0] w(logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  function automatic logic [31:0] word_at(logic [31:0] a);
    return (a == ovr_addr) ? ovr_word : w(a);
  endfunction

  function automatic vec_t mk(logic st, logic [1:0] jb, logic [31:0] br, logic [31:0] jp, logic rdy,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ei, logic [31:0] ep);
    vec_t v;
    v.stall = st; v.jb = jb; v.br = br; v.jp = jp; v.ready = rdy;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc4 = ep;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: accepts when req&ready at the edge, answers mem_lat cycles later.
  task automatic tick();
    if (bus.req && bus.ready) begin
      pend      = 1'b1;
      pend_addr = bus.addr;
      pend_cnt  = mem_lat;
    end
    @(posedge clk);
    @(negedge clk);
    bus.rvalid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.rvalid = 1'b1;
        bus.rdata  = word_at(pend_addr);
        pend       = 1'b0;
      end
    end
  endtask

  task automatic check_out(string tag, logic e_req, logic [31:0] e_addr, logic e_valid,
                           logic [31:0] e_instr, logic [31:0] e_pc4);
    chk({tag, ".req"}, 32'(bus.req), 32'(e_req));
    if (e_req) chk({tag, ".addr"}, bus.addr, e_addr);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(e_valid));
    chk({tag, ".instr"}, if_id_instr, e_instr);
    if (e_valid) chk({tag, ".pc4"}, if_id_pc4, e_pc4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; pend = 1'b0; bus.rvalid = 1'b0;
    stall = 1'b0; jb_flag = 2'b00; bus.ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[$];
    bit   seen;

    bus.ready = 1'b1; bus.rvalid = 1'b0; bus.rdata = 32'h0;

    // streaming, branch on accept of 0x10 after ready-low, unaligned jump, illegal code, redirect on rvalid
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 0, 32'h04, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 1, 32'h04, 1, w(32'h00), 32'h04));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 0, 32'h08, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 1, 32'h08, 1, w(32'h04), 32'h08));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 0, 32'h0C, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 1, 32'h0C, 1, w(32'h08), 32'h0C));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 0, 32'h10, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 1, 32'h10, 1, w(32'h0C), 32'h10));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0, 2'b00, 0, 0, 0, 1, 32'h10, 0, NOP, 0));
    tv.push_back(mk(0, 2'b01, 32'h24, 0, 1, 0, 32'h24, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 1, 32'h24, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 0, 32'h28, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 1, 32'h28, 1, w(32'h24), 32'h28));
    tv.push_back(mk(0, 2'b10, 0, 32'h63, 1, 0, 32'h60, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 1, 32'h60, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 0, 32'h64, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 1, 32'h64, 1, w(32'h60), 32'h64));
    tv.push_back(mk(0, 2'b11, 32'h44, 32'h80, 0, 1, 32'h80, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 0, 32'h84, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 1, 32'h84, 1, w(32'h80), 32'h84));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 0, 32'h88, 0, NOP, 0));
    tv.push_back(mk(0, 2'b01, 32'h101, 0, 1, 1, 32'h100, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 0, 32'h104, 0, NOP, 0));
    tv.push_back(mk(0, 2'b00, 0, 0, 1, 1, 32'h104, 1, w(32'h100), 32'h104));

    // reset values while reset is high
    @(negedge clk); #1;
    chk("rst.req", 32'(bus.req), 32'h0);
    chk("rst.addr", bus.addr, 32'h0);
    chk("rst.valid", 32'(if_id_valid), 32'h0);
    chk("rst.instr", if_id_instr, NOP);
    chk("rst.pc4", if_id_pc4, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel.req", 32'(bus.req), 32'h1);
    chk("rel.addr", bus.addr, 32'h0);

    for (int i = 0; i < tv.size(); i++) begin
      stall = tv[i].stall; jb_flag = tv[i].jb; branch_addr = tv[i].br;
      jump_addr = tv[i].jp; bus.ready = tv[i].ready;
      tick();
      check_out($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_addr, tv[i].e_valid,
                tv[i].e_instr, tv[i].e_pc4);
    end
    jb_flag = 2'b00;

    // stall while the response returns: word parks in the skid buffer, jb_flag ignored
    do_reset();
    ovr_addr = 32'h0; ovr_word = 32'h2008_0005;
    tick();
    check_out("stl.acc", 0, 0, 0, NOP, 0);
    stall = 1'b1;
    tick();
    check_out("stl.c1", 0, 0, 0, NOP, 0);
    jb_flag = 2'b10; jump_addr = 32'h200;
    tick();
    check_out("stl.c2", 0, 0, 0, NOP, 0);
    jb_flag = 2'b00;
    tick();
    check_out("stl.c3", 0, 0, 0, NOP, 0);
    stall = 1'b0;
    tick();
    check_out("stl.out", 1, 32'h04, 1, 32'h2008_0005, 32'h04);
    stall = 1'b1; bus.ready = 1'b0;
    tick();
    check_out("stl.hold", 1, 32'h04, 1, 32'h2008_0005, 32'h04);
    stall = 1'b0; bus.ready = 1'b1;
    tick();
    check_out("stl.acc2", 0, 0, 0, NOP, 0);
    tick();
    check_out("stl.nxt", 1, 32'h08, 1, w(32'h04), 32'h08);
    ovr_addr = 32'hFFFF_FFFF;

    // jump while WAIT with a slow memory: in-flight word killed on arrival
    mem_lat = 3;
    do_reset();
    tick();
    check_out("jmp.acc", 0, 0, 0, NOP, 0);
    jb_flag = 2'b10; jump_addr = 32'h40;
    tick();
    jb_flag = 2'b00;
    check_out("jmp.w1", 0, 0, 0, NOP, 0);
    tick();
    check_out("jmp.w2", 0, 0, 0, NOP, 0);
    tick();
    check_out("jmp.req", 1, 32'h40, 0, NOP, 0);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      seen = if_id_valid;
    end
    chk("jmp.arrive", 32'(seen), 32'h1);
    chk("jmp.instr", if_id_instr, w(32'h40));
    chk("jmp.pc4", if_id_pc4, 32'h44);

    // asynchronous reset in the middle of WAIT
    mem_lat = 1;
    do_reset();
    tick();
    tick();
    check_out("ar.pre", 1, 32'h04, 1, w(32'h00), 32'h04);
    tick();
    #2;
    reset = 1'b1; pend = 1'b0; bus.rvalid = 1'b0;
    #1;
    chk("ar.req", 32'(bus.req), 32'h0);
    chk("ar.addr", bus.addr, 32'h0);
    chk("ar.valid", 32'(if_id_valid), 32'h0);
    chk("ar.instr", if_id_instr, NOP);
    chk("ar.pc4", if_id_pc4, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ar.rel_req", 32'(bus.req), 32'h1);
    chk("ar.rel_addr", bus.addr, 32'h0);
    tick();
    tick();
    check_out("ar.first", 1, 32'h04, 1, w(32'h00), 32'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
